ifetch_line_buffer: RTL



---
 rtl/ifetch_line_buffer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ifetch_line_buffer.sv
// Instruction-fetch line buffer between the fetch stage and a 32x128 synchronous ROM.
// Define IFETCH_PERF_EN to add saturating hit/miss counters (hit_count, miss_count).
module ifetch_line_buffer #(
  parameter int          ROM_ADDR_W = 5,
  parameter int          LINE_W     = 128,
  parameter int          WORD_W     = 32,
  parameter logic [31:0] TRAP_INSTR = 32'h1000ffff
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_pc,
  input  logic                  flush,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [LINE_W-1:0]     rom_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WORD_W-1:0]     rsp_instr,
  output logic [31:0]           rsp_pc,
  output logic                  rsp_err
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
`endif
);

  localparam int LINE_LSB = 4;
  localparam int LINE_MSB = ROM_ADDR_W + 3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LINE_W-1:0]     r_line;
  logic [ROM_ADDR_W-1:0] r_line_tag;
  logic                  r_line_valid;
  logic [31:0]           r_fill_pc;
  logic                  r_rsp_valid;
  logic [WORD_W-1:0]     r_rsp_instr;
  logic [31:0]           r_rsp_pc;
  logic                  r_rsp_err;

  logic                  w_err;
  logic                  w_hit;
  logic                  w_accept;
  logic                  w_miss_accept;

  function automatic logic [WORD_W-1:0] f_word_sel(input logic [LINE_W-1:0] line,
                                                   input logic [1:0]        idx);
    case (idx)
      2'd0:    f_word_sel = line[0*WORD_W +: WORD_W];
      2'd1:    f_word_sel = line[1*WORD_W +: WORD_W];
      2'd2:    f_word_sel = line[2*WORD_W +: WORD_W];
      default: f_word_sel = line[3*WORD_W +: WORD_W];
    endcase
  endfunction

  assign w_err         = (req_pc[1:0] != 2'b00) || (|req_pc[31:LINE_MSB+1]);
  assign w_hit         = r_line_valid && (r_line_tag == req_pc[LINE_MSB:LINE_LSB]);
  assign req_ready     = (r_state == S_IDLE) && !flush && (!r_rsp_valid || rsp_ready);
  assign w_accept      = req_valid && req_ready;
  assign w_miss_accept = w_accept && !w_err && !w_hit;

  // The ROM only sees a new line address on an accepted miss; otherwise it re-reads the held line.
  assign rom_addr  = w_miss_accept ? req_pc[LINE_MSB:LINE_LSB] : r_line_tag;

  assign rsp_valid = r_rsp_valid;
  assign rsp_instr = r_rsp_instr;
  assign rsp_pc    = r_rsp_pc;
  assign rsp_err   = r_rsp_err;

  // Next-state logic: a fill always lasts exactly one cycle, flushed or not.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_miss_accept) begin
          w_state_nxt = S_FILL;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FILL:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, line buffer and pending-fill PC.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_line       <= '0;
      r_line_tag   <= '0;
      r_line_valid <= 1'b0;
      r_fill_pc    <= 32'h0000_0000;
    end else begin
      r_state <= w_state_nxt;
      if (w_miss_accept) begin
        r_fill_pc <= req_pc;
      end
      if ((r_state == S_FILL) && !flush) begin
        r_line       <= rom_data;
        r_line_tag   <= r_fill_pc[LINE_MSB:LINE_LSB];
        r_line_valid <= 1'b1;
      end
    end
  end

  // Response register: flush wins, then hit/error load, then fill load, then handshake drain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_instr <= '0;
      r_rsp_pc    <= 32'h0000_0000;
      r_rsp_err   <= 1'b0;
    end else if (flush) begin
      r_rsp_valid <= 1'b0;
    end else if (w_accept && (w_err || w_hit)) begin
      r_rsp_valid <= 1'b1;
      r_rsp_instr <= w_err ? TRAP_INSTR[WORD_W-1:0] : f_word_sel(r_line, req_pc[3:2]);
      r_rsp_pc    <= req_pc;
      r_rsp_err   <= w_err;
    end else if (r_state == S_FILL) begin
      r_rsp_valid <= 1'b1;
      r_rsp_instr <= f_word_sel(rom_data, r_fill_pc[3:2]);
      r_rsp_pc    <= r_fill_pc;
      r_rsp_err   <= 1'b0;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

  // Saturating counters of accepted non-error requests.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_count  <= 16'h0000;
      r_miss_count <= 16'h0000;
    end else begin
      if (w_accept && !w_err && w_hit && (r_hit_count != 16'hffff)) begin
        r_hit_count <= r_hit_count + 16'd1;
      end
      if (w_miss_accept && (r_miss_count != 16'hffff)) begin
        r_miss_count <= r_miss_count + 16'd1;
      end
    end
  end
`endif

endmodule
